// File: rtl/dmem_arbiter_if.sv
// Bundled bus signals for dmem_arbiter: core port, debug/loader port and the memory side.
// The slave modport is the arbiter's view; the master modport is the requester/memory view.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_stall;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_lock;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for a single-port synchronous data memory with read-ownership tracking.
// Define DMEM_ARB_RR_EN for round-robin on contention; otherwise the core has fixed priority.
module dmem_arbiter (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {RspNone, RspCore, RspDbg} rsp_e;

    rsp_e rsp_own_q, rsp_own_d;
    logic last_own_q, last_own_d;
    logic lock_own_q, lock_own_d;

    logic c_gnt, d_gnt;
    logic locked;
    logic c_win;

    always_comb begin
        c_gnt  = 1'b0;
        d_gnt  = 1'b0;
        c_win  = 1'b1;
        // A set lock only holds while d_lock stays high, so the core can win the cycle it drops.
        locked = lock_own_q & bus.d_lock;
        if (reset) begin
            if (locked) begin
                d_gnt = bus.d_req;
            end else if (bus.c_req && bus.d_req) begin
`ifdef DMEM_ARB_RR_EN
                c_win = last_own_q;
`else
                c_win = 1'b1;
`endif
                c_gnt = c_win;
                d_gnt = ~c_win;
            end else begin
                c_gnt = bus.c_req;
                d_gnt = bus.d_req;
            end
        end
    end

    always_comb begin
        last_own_d = last_own_q;
        if (d_gnt) begin
            last_own_d = 1'b1;
        end else if (c_gnt) begin
            last_own_d = 1'b0;
        end

        rsp_own_d = RspNone;
        if (c_gnt && !bus.c_we) begin
            rsp_own_d = RspCore;
        end else if (d_gnt && !bus.d_we) begin
            rsp_own_d = RspDbg;
        end

        lock_own_d = bus.d_lock & (lock_own_q | d_gnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_own_q <= 1'b1;
            rsp_own_q  <= RspNone;
            lock_own_q <= 1'b0;
        end else begin
            last_own_q <= last_own_d;
            rsp_own_q  <= rsp_own_d;
            lock_own_q <= lock_own_d;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.c_stall  = bus.c_req & ~c_gnt;

    assign bus.m_en     = c_gnt | d_gnt;
    assign bus.m_we     = d_gnt ? bus.d_we    : (c_gnt & bus.c_we);
    assign bus.m_addr   = d_gnt ? bus.d_addr  : bus.c_addr;
    assign bus.m_wdata  = d_gnt ? bus.d_wdata : bus.c_wdata;

    assign bus.c_rvalid = (rsp_own_q == RspCore);
    assign bus.d_rvalid = (rsp_own_q == RspDbg);
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected read responses,
// a negedge monitor pops and compares them whenever an rvalid appears.
module tb_dmem_arbiter;

    typedef struct {
        int         cyc;
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    logic [7:0] mem [256];
    logic [7:0] rdata_q;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          rdata_q <= mem[bus.m_addr];
        end
    end
    assign bus.m_rdata = rdata_q;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic port, input logic [7:0] data);
        q.push_back('{cyc: cyc + 1, port: port, data: data});
    endtask

    task automatic drv(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                       input logic dl);
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        bus.d_lock = dl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the head of the queue in the expected cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.c_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
            chk("rvalid_onehot", bus.c_rvalid & bus.d_rvalid, 1'b0);
            if (q.size() == 0 || q[0].cyc != cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rvalid: got c=%b d=%b required none (cycle %0d)",
                         bus.c_rvalid, bus.d_rvalid, cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_port", bus.d_rvalid, e.port);
                chkb("rsp_data", bus.d_rvalid ? bus.d_rdata : bus.c_rdata, e.data);
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_rvalid: got none required port %b data %h (cycle %0d)",
                     e.port, e.data, cyc);
        end
    end

    initial begin
        logic cw;
        n_vec = 0;
        n_err = 0;
        rdata_q = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h08] = 8'h0A;
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        mem[8'h30] = 8'h33;
        mem[8'h31] = 8'h44;

        drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_c_gnt", bus.c_gnt, 1'b0);
        chk("rst_d_gnt", bus.d_gnt, 1'b0);
        chk("rst_c_stall", bus.c_stall, 1'b0);
        chk("rst_m_en", bus.m_en, 1'b0);
        chk("rst_m_we", bus.m_we, 1'b0);
        chk("rst_c_rvalid", bus.c_rvalid, 1'b0);
        chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
        step();
        reset = 1'b1;

        // Single core read
        step(); drv(1, 0, 8'h08, 8'h00, 0, 0, 8'h00, 8'h00, 0); #3;
        chk("single_c_gnt", bus.c_gnt, 1'b1);
        chk("single_d_gnt", bus.d_gnt, 1'b0);
        chk("single_m_en", bus.m_en, 1'b1);
        chkb("single_m_addr", bus.m_addr, 8'h08);
        push(1'b0, 8'h0A);

        // Single debug read leaves last_own = debug
        step(); drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0); #3;
        chk("dbg_d_gnt", bus.d_gnt, 1'b1);
        chk("dbg_c_gnt", bus.c_gnt, 1'b0);
        push(1'b1, 8'h11);

        // Four cycles of contention
        for (int i = 0; i < 4; i++) begin
            step(); drv(1, 0, 8'h21, 8'h00, 1, 0, 8'h30, 8'h00, 0); #3;
`ifdef DMEM_ARB_RR_EN
            cw = (i % 2 == 0);
`else
            cw = 1'b1;
`endif
            chk("cont_c_gnt", bus.c_gnt, cw);
            chk("cont_d_gnt", bus.d_gnt, ~cw);
            chk("cont_c_stall", bus.c_stall, ~cw);
            if (cw) push(1'b0, 8'h22);
            else    push(1'b1, 8'h33);
        end
        step(); drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0); #3;
        chk("after_cont_d_gnt", bus.d_gnt, 1'b1);
        push(1'b1, 8'h33);

        // Lock: debug takes the lock, then writes twice while the core waits
        step(); drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00, 1); #3;
        chk("lock_take_d_gnt", bus.d_gnt, 1'b1);
        push(1'b1, 8'h44);
        step(); drv(1, 0, 8'h09, 8'h00, 1, 1, 8'h09, 8'h01, 1); #3;
        chk("lock_w1_c_stall", bus.c_stall, 1'b1);
        chk("lock_w1_d_gnt", bus.d_gnt, 1'b1);
        chk("lock_w1_m_we", bus.m_we, 1'b1);
        chkb("lock_w1_m_addr", bus.m_addr, 8'h09);
        step(); drv(1, 0, 8'h09, 8'h00, 1, 1, 8'h0A, 8'h02, 1); #3;
        chk("lock_w2_c_stall", bus.c_stall, 1'b1);
        chk("lock_w2_d_gnt", bus.d_gnt, 1'b1);
        chkb("lock_w2_m_wdata", bus.m_wdata, 8'h02);
        step(); drv(1, 0, 8'h09, 8'h00, 0, 0, 8'h00, 8'h00, 0); #3;
        chk("unlock_c_gnt", bus.c_gnt, 1'b1);
        chk("unlock_c_stall", bus.c_stall, 1'b0);
        push(1'b0, 8'h01);

        // Write then read of the same address
        step(); drv(1, 1, 8'h0A, 8'h0B, 0, 0, 8'h00, 8'h00, 0); #3;
        chk("wr_c_gnt", bus.c_gnt, 1'b1);
        chk("wr_m_we", bus.m_we, 1'b1);
        chkb("wr_m_wdata", bus.m_wdata, 8'h0B);
        step(); drv(1, 0, 8'h0A, 8'h00, 0, 0, 8'h00, 8'h00, 0); #3;
        chk("rd_c_gnt", bus.c_gnt, 1'b1);
        chk("rd_m_we", bus.m_we, 1'b0);
        push(1'b0, 8'h0B);

        // Reset during a pending read drops the response
        step(); drv(1, 0, 8'h08, 8'h00, 0, 0, 8'h00, 8'h00, 0); #3;
        chk("pre_rst_c_gnt", bus.c_gnt, 1'b1);
        step(); reset = 1'b0; drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0); #3;
        chk("midrst_c_rvalid", bus.c_rvalid, 1'b0);
        chk("midrst_c_gnt", bus.c_gnt, 1'b0);
        chk("midrst_d_gnt", bus.d_gnt, 1'b0);
        chk("midrst_m_en", bus.m_en, 1'b0);
        step(); reset = 1'b1; drv(1, 0, 8'h08, 8'h00, 1, 0, 8'h20, 8'h00, 0); #3;
        chk("postrst_c_gnt", bus.c_gnt, 1'b1);
        chk("postrst_d_gnt", bus.d_gnt, 1'b0);
        push(1'b0, 8'h0A);
        step(); drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0); #3;
        chk("postrst_d_gnt2", bus.d_gnt, 1'b1);
        push(1'b1, 8'h11);

        step(); drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        repeat (3) @(posedge clk);
        #6;
        chk("queue_drained", q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port synchronous data memory between the `risc_core` data port and a debug/loader port. The loader preloads data such as operands for `LW`, and inspects results such as `SW` targets. Arbitration happens each cycle with a same-cycle grant. The block tracks read ownership so the one-cycle memory read response is returned only to the port that issued it. An optional lock lets the loader hold the memory for multi-word transfers.

## Interface
Parameters:
- `AW`, 8, address width (matches core `data_addr`)
- `DW`, 8, data width (matches core `data_out`/`data_in`)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `c_req`  in  1  core access request; held with payload until `c_gnt`
- `c_we`  in  1  core write enable (1 = write, 0 = read)
- `c_addr`  in  AW  core address
- `c_wdata`  in  DW  core write data
- `c_gnt`  out  1  core request accepted this cycle
- `c_stall`  out  1  `c_req & ~c_gnt`; freezes the core pipeline
- `c_rvalid`  out  1  core read data valid
- `c_rdata`  out  DW  core read data
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: debug port, same meanings and widths
- `d_lock`  in  1  debug requests exclusive ownership while asserted
- `m_en`  out  1  memory access strobe
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid one cycle after a read strobe

## Operation
- At most one grant per cycle. The granted port's `we`, `addr` and `wdata` drive `m_*` combinationally, and `m_en = c_gnt | d_gnt`.
- Arbitration state:
  - `last_own`: 1 bit, 0 = core, 1 = debug. Updated on every grant.
  - `rsp_own`: 2 bits, none/core/debug. Set on a read grant, cleared otherwise.
  - `lock_own`: 1 bit.
- Lock:
  - `lock_own` sets on a cycle with `d_gnt & d_lock`.
  - `lock_own` clears on any cycle with `d_lock == 0`.
  - While `lock_own` is set, only the debug port can be granted. `c_req` stalls regardless of priority mode.
- Contention (`c_req & d_req`, not locked) is resolved by the priority mode (see Configuration).
- A single requester is always granted when not locked out.
- Read response: in the cycle after a read grant, `x_rvalid = 1` for the owning port only and `x_rdata = m_rdata`.
  - `x_rdata` is don't-care when `x_rvalid = 0`. Benches check data only on `x_rvalid`.
- Writes produce no `rvalid`.
- Withdrawing `req` before grant is legal and has no side effects.
- Changing the payload while `req` is high and ungranted is a protocol violation. Results are undefined.

## Timing
- Reset values: `c_gnt`, `d_gnt`, `c_stall`, `m_en`, `m_we`, `c_rvalid`, `d_rvalid` all 0. `last_own = 1`, `rsp_own = none`, `lock_own = 0`.
- All grants are forced to 0 while `reset` is low.
- Grant latency is 0 cycles: request in cycle N, grant in cycle N when not contended.
- Read data latency: `x_rvalid` in cycle N+1 for a grant in cycle N.
- Throughput: one access per cycle. Back-to-back reads from either port or alternating ports are sustained, with `rvalid` pipelined every cycle.
- A read in cycle N and a write from the other port in cycle N+1 are both legal. The response for N still goes to the original owner.
- Reset asserted mid-read: the pending `rvalid` is dropped (0) and `rsp_own` is cleared asynchronously.
- If `d_lock` drops in the same cycle as a `c_req`, the core may be granted that same cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on contention. The port not equal to `last_own` wins, so contended requests alternate core, debug, core, and so on. The first contention after reset goes to the core.
- `DMEM_ARB_RR_EN` undefined: fixed priority with the core always winning on contention. The debug port can starve while the core requests every cycle. `last_own` still updates but does not affect arbitration.

## Test plan
- Single core read: after reset release, `c_req=1`, `c_we=0`, `c_addr=8'h08`, memory holds `8'h0A` → `c_gnt=1` in the same cycle, `m_addr=8'h08`, next cycle `c_rvalid=1`, `c_rdata=8'h0A`, `d_rvalid=0`.
- Contention with `DMEM_ARB_RR_EN`: both ports request reads every cycle for 4 cycles → grant order core, debug, core, debug. `c_stall` is high in cycles 2 and 4, and each `rvalid` is routed to its own port.
- Contention without macro: both ports request for 4 cycles → `c_gnt=1` every cycle, `d_gnt=0` throughout. `d_gnt=1` the cycle after `c_req` drops.
- Lock: debug writes `8'h01` to `8'h09`, then `8'h02` to `8'h0A`, with `d_lock=1` while `c_req` is held high → `c_stall=1` for both cycles. Core is granted the cycle `d_lock` drops, and a core read of `8'h09` returns `8'h01`.
- Reset mid-read: core read granted in cycle N, `reset` driven low in cycle N+1 before the edge → `c_rvalid=0`, all grants 0. After release, a first contended request goes to the core in both modes.
- Write then read: core writes `8'h0B` to `8'h0A` in cycle N, core reads `8'h0A` in cycle N+1 → `c_rvalid` only in N+2 with `c_rdata=8'h0B`, no `rvalid` in N+1.
